// File: rtl/lc4_fetch_pkg.sv
// Shared types and constants for the LC4 instruction fetch requester.
// Holds the fetch pair bundle, the reset PC and the memory latency limit.
package lc4_fetch_pkg;

  localparam logic [15:0] LC4_RESET_PC        = 16'h8200;
  localparam int          LC4_MAX_MEM_LATENCY = 8;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] insn1;
    logic [15:0] insn2;
  } fetch_pair_t;

endpackage

// File: rtl/lc4_fetch_fifo.sv
// Pair FIFO with a registered head, synchronous flush and async reset.
// Ports: i_push/i_data in, i_pop, i_flush, o_count, o_valid, o_head out.
module lc4_fetch_fifo
  import lc4_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_pair_t   i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_valid,
  output fetch_pair_t   o_head
);

  fetch_pair_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_valid;
  fetch_pair_t   r_head;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_n;
  logic [CW-1:0] w_left;
  logic [CW-1:0] w_cnt_n;
  fetch_pair_t   w_head_n;

  assign w_pop   = i_pop & r_valid;
  assign w_push  = i_push & ((r_count != CW'(DEPTH)) | w_pop);
  assign w_rd_n  = r_rd + AW'(w_pop);
  assign w_left  = r_count - CW'(w_pop);
  assign w_cnt_n = w_left + CW'(w_push);

  // Once the pop drains the queue, the new head is the entry being
  // written this cycle, so bypass it straight into the head register.
  assign w_head_n = (w_left == '0) ? i_data : r_mem[w_rd_n];

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_n;
      r_count <= w_cnt_n;
      r_valid <= (w_cnt_n != '0);
      if (w_cnt_n != '0) r_head <= w_head_n;
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_head  = r_head;

endmodule

// File: rtl/lc4_fetch_requester.sv
// LC4 dual-port instruction fetch initiator with latency tracking and FIFO.
// Ports: gwe/rst control, i1/i2 read ports, redirect, out_* decode handshake.
module lc4_fetch_requester
  import lc4_fetch_pkg::*;
#(
  parameter int          LATENCY    = 0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = LC4_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gwe,
  output logic        i1re,
  output logic        i2re,
  output logic [15:0] i1addr,
  output logic [15:0] i2addr,
  input  logic [15:0] i1in,
  input  logic [15:0] i2in,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [15:0] out_insn1,
  output logic [15:0] out_insn2
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   r_pc;
  logic [CW-1:0] w_fcount;
  logic [3:0]    w_infl;
  logic          w_credit;
  logic          w_issue;
  logic          w_redir;
  logic          w_cap;
  logic [15:0]   w_cap_pc;
  logic          w_pop;
  fetch_pair_t   w_head;

  assign w_redir  = gwe & redirect_valid;
  // In-flight requests already own a FIFO slot, so the FIFO cannot overflow.
  assign w_credit = (int'(w_fcount) + int'(w_infl)) < FIFO_DEPTH;
  assign w_issue  = ~rst & gwe & ~redirect_valid & w_credit;

  assign i1re   = w_issue;
  assign i2re   = w_issue;
  assign i1addr = r_pc;
  assign i2addr = r_pc + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redir) begin
      r_pc <= redirect_pc;
    end else if (w_issue) begin
      r_pc <= r_pc + 16'd2;
    end
  end

  if (LATENCY == 0) begin : g_lat0
    assign w_cap    = w_issue;
    assign w_cap_pc = r_pc;
    assign w_infl   = 4'd0;
  end else begin : g_pipe
    logic        r_vld [LATENCY];
    logic [15:0] r_spc [LATENCY];
    logic [3:0]  r_cnt;

    assign w_cap    = r_vld[LATENCY-1] & gwe & ~redirect_valid;
    assign w_cap_pc = r_spc[LATENCY-1];
    assign w_infl   = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) begin
          r_vld[i] <= 1'b0;
          r_spc[i] <= '0;
        end
        r_cnt <= '0;
      end else if (gwe) begin
        r_spc[0] <= r_pc;
        for (int i = 1; i < LATENCY; i++) begin
          r_spc[i] <= r_spc[i-1];
        end
        if (redirect_valid) begin
          for (int i = 0; i < LATENCY; i++) begin
            r_vld[i] <= 1'b0;
          end
          r_cnt <= '0;
        end else begin
          r_vld[0] <= w_issue;
          for (int i = 1; i < LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
          end
          r_cnt <= r_cnt + 4'(w_issue) - 4'(r_vld[LATENCY-1]);
        end
      end
    end
  end

  assign w_pop = out_valid & out_ready & gwe & ~redirect_valid;

  lc4_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cap),
    .i_data  ('{pc: w_cap_pc, insn1: i1in, insn2: i2in}),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .o_count (w_fcount),
    .o_valid (out_valid),
    .o_head  (w_head)
  );

  assign out_pc    = w_head.pc;
  assign out_insn1 = w_head.insn1;
  assign out_insn2 = w_head.insn2;

endmodule

// File: tb/tb_lc4_fetch_requester.sv
// Directed bench for lc4_fetch_requester at LATENCY 0 and 8.
// Three instances share stimulus; each test checks the relevant one.
module tb_lc4_fetch_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_ready;

  always #5 clk = ~clk;

  function automatic logic [15:0] mw(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  logic        a_i1re, a_i2re, a_ov;
  logic [15:0] a_i1addr, a_i2addr, a_i1in, a_i2in;
  logic [15:0] a_opc, a_oi1, a_oi2;
  logic        b_i1re, b_i2re, b_ov;
  logic [15:0] b_i1addr, b_i2addr, b_i1in, b_i2in;
  logic [15:0] b_opc, b_oi1, b_oi2;
  logic        c_i1re, c_i2re, c_ov;
  logic [15:0] c_i1addr, c_i2addr, c_i1in, c_i2in;
  logic [15:0] c_opc, c_oi1, c_oi2;

  logic [15:0] b_dl1 [8];
  logic [15:0] b_dl2 [8];
  logic [15:0] c_dl1 [8];
  logic [15:0] c_dl2 [8];

  assign a_i1in = mw(a_i1addr);
  assign a_i2in = mw(a_i2addr);
  assign b_i1in = mw(b_dl1[7]);
  assign b_i2in = mw(b_dl2[7]);
  assign c_i1in = mw(c_dl1[7]);
  assign c_i2in = mw(c_dl2[7]);

  // Memory delay lines stall on gwe, like the real memory block.
  always @(posedge clk) begin
    if (gwe) begin
      b_dl1[0] <= b_i1addr;
      b_dl2[0] <= b_i2addr;
      c_dl1[0] <= c_i1addr;
      c_dl2[0] <= c_i2addr;
      for (int k = 1; k < 8; k++) begin
        b_dl1[k] <= b_dl1[k-1];
        b_dl2[k] <= b_dl2[k-1];
        c_dl1[k] <= c_dl1[k-1];
        c_dl2[k] <= c_dl2[k-1];
      end
    end
  end

  lc4_fetch_requester #(.LATENCY(0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i1re(a_i1re), .i2re(a_i2re), .i1addr(a_i1addr), .i2addr(a_i2addr),
    .i1in(a_i1in), .i2in(a_i2in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(a_ov), .out_ready(out_ready),
    .out_pc(a_opc), .out_insn1(a_oi1), .out_insn2(a_oi2)
  );

  lc4_fetch_requester #(.LATENCY(8), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i1re(b_i1re), .i2re(b_i2re), .i1addr(b_i1addr), .i2addr(b_i2addr),
    .i1in(b_i1in), .i2in(b_i2in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(b_ov), .out_ready(out_ready),
    .out_pc(b_opc), .out_insn1(b_oi1), .out_insn2(b_oi2)
  );

  lc4_fetch_requester #(.LATENCY(8), .FIFO_DEPTH(8)) u_c (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i1re(c_i1re), .i2re(c_i2re), .i1addr(c_i1addr), .i2addr(c_i2addr),
    .i1in(c_i1in), .i2in(c_i2in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(c_ov), .out_ready(out_ready),
    .out_pc(c_opc), .out_insn1(c_oi1), .out_insn2(c_oi2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int          issues;
  int          edges;
  int          pops;
  logic [15:0] exp_pc;

  initial begin
    rst            = 1'b1;
    gwe            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    for (int k = 0; k < 8; k++) begin
      b_dl1[k] = '0; b_dl2[k] = '0;
      c_dl1[k] = '0; c_dl2[k] = '0;
    end

    @(negedge clk); #1;
    chk("rst_ov",    32'(a_ov),     32'h0);
    chk("rst_re",    32'(a_i1re),   32'h0);
    chk("rst_addr1", 32'(a_i1addr), 32'h8200);
    chk("rst_addr2", 32'(a_i2addr), 32'h8201);
    chk("rst_opc",   32'(a_opc),    32'h0);
    chk("rst_b_ov",  32'(b_ov),     32'h0);

    // 1: zero latency streaming
    rst = 1'b0; #1;
    chk("t1_re",  32'(a_i1re),   32'h1);
    chk("t1_a1",  32'(a_i1addr), 32'h8200);
    chk("t1_ov0", 32'(a_ov),     32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t1_ov",  32'(a_ov),  32'h1);
      chk("t1_pc",  32'(a_opc), 32'(16'h8200 + 16'(2*k)));
      chk("t1_i1",  32'(a_oi1), 32'(mw(16'h8200 + 16'(2*k))));
      chk("t1_i2",  32'(a_oi2), 32'(mw(16'h8201 + 16'(2*k))));
    end

    // 4: pc wrap at FFFE
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE; #1;
    chk("t4_rd_re", 32'(a_i1re), 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    chk("t4_a1",  32'(a_i1addr), 32'hFFFE);
    chk("t4_a2",  32'(a_i2addr), 32'hFFFF);
    chk("t4_re",  32'(a_i1re),   32'h1);
    chk("t4_ov0", 32'(a_ov),     32'h0);
    @(negedge clk); #1;
    chk("t4_w1",  32'(a_i1addr), 32'h0000);
    chk("t4_w2",  32'(a_i2addr), 32'h0001);
    chk("t4_opc", 32'(a_opc),    32'hFFFE);
    chk("t4_oi2", 32'(a_oi2),    32'(mw(16'hFFFF)));
    @(negedge clk); #1;
    chk("t4_opc2", 32'(a_opc),   32'h0000);

    // 2: credit limit with decode stalled
    rst_pulse();
    out_ready = 1'b0;
    issues    = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      issues += int'(b_i1re);
      if (i == 8) chk("t2_ov8", 32'(b_ov), 32'h0);
      if (i == 9) chk("t2_ov9", 32'(b_ov), 32'h1);
      @(negedge clk);
    end
    #1;
    chk("t2_issues", 32'(issues),  32'd4);
    chk("t2_re",     32'(b_i1re),  32'h0);
    chk("t2_ov",     32'(b_ov),    32'h1);
    chk("t2_opc",    32'(b_opc),   32'h8200);
    chk("t2_oi1",    32'(b_oi1),   32'(mw(16'h8200)));
    out_ready = 1'b1; #1;
    chk("t2_full_re", 32'(b_i1re), 32'h0);
    @(negedge clk); #1;
    chk("t2_resume",  32'(b_i1re),   32'h1);
    chk("t2_raddr",   32'(b_i1addr), 32'h8208);
    chk("t2_opc2",    32'(b_opc),    32'h8202);

    // 3: redirect mid-stream
    for (int i = 0; i < 12; i++) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100; #1;
    chk("t3_rd_re", 32'(b_i1re), 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    chk("t3_ov0", 32'(b_ov),     32'h0);
    chk("t3_a1",  32'(b_i1addr), 32'h0100);
    chk("t3_re",  32'(b_i1re),   32'h1);
    edges = 0;
    while (!b_ov && edges < 30) begin
      @(negedge clk); #1;
      edges++;
    end
    chk("t3_lat", 32'(edges),  32'd9);
    chk("t3_opc", 32'(b_opc),  32'h0100);
    chk("t3_oi1", 32'(b_oi1),  32'(mw(16'h0100)));
    chk("t3_oi2", 32'(b_oi2),  32'(mw(16'h0101)));

    // 5: gwe stall keeps sequence intact
    rst_pulse();
    exp_pc = 16'h8200;
    pops   = 0;
    for (int i = 0; i < 42; i++) begin
      gwe = !(i >= 12 && i < 17); #1;
      if (!gwe) begin
        chk("t5_stall_re", 32'(b_i1re), 32'h0);
        if (b_ov) chk("t5_hold", 32'(b_opc), 32'(exp_pc));
      end else if (b_ov) begin
        chk("t5_pc",  32'(b_opc), 32'(exp_pc));
        chk("t5_i1",  32'(b_oi1), 32'(mw(exp_pc)));
        exp_pc += 16'd2;
        pops++;
      end
      @(negedge clk);
    end
    gwe = 1'b1;
    chk("t5_pops", 32'(pops >= 8), 32'h1);

    // 6: reset with requests in flight
    rst_pulse();
    for (int i = 0; i < 10; i++) @(negedge clk);
    #1;
    chk("t6_ov_pre",  32'(c_ov),  32'h1);
    chk("t6_opc_pre", 32'(c_opc), 32'h8202);
    rst = 1'b1; #1;
    chk("t6_ov_rst", 32'(c_ov),     32'h0);
    chk("t6_re_rst", 32'(c_i1re),   32'h0);
    chk("t6_a_rst",  32'(c_i1addr), 32'h8200);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("t6_first", 32'(c_i1addr), 32'h8200);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t6_stale", 32'(c_ov), 32'h0);
      @(negedge clk);
    end
    #1;
    chk("t6_ov",  32'(c_ov),  32'h1);
    chk("t6_opc", 32'(c_opc), 32'h8200);
    chk("t6_oi1", 32'(c_oi1), 32'(mw(16'h8200)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
